// File: rtl/llc_rst_flush_seq_pkg.sv
// Shared LLC definitions for the reset/flush walk sequencer: set geometry and FSM states.
package llc_rst_flush_seq_pkg;

   localparam int unsigned LLC_SETS     = 1024;
   localparam int unsigned LLC_SET_BITS = $clog2(LLC_SETS);

   typedef logic [LLC_SET_BITS-1:0] llc_set_t;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_ISSUE = 2'd1,
      SEQ_WAIT  = 2'd2,
      SEQ_RESP  = 2'd3
   } llc_seq_state_t;

endpackage

// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush walk sequencer: one op per set, stall outputs gate request intake.
// Optional walk cycle counter enabled by defining LLC_SEQ_CYCLE_CNT_EN.
module llc_rst_flush_seq
   import llc_rst_flush_seq_pkg::*;
#(
   parameter int unsigned SETS     = LLC_SETS,
   parameter int unsigned SET_BITS = $clog2(SETS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_is_flush,
   output logic                op_valid,
   input  logic                op_ready,
   output logic                op_is_flush,
   output logic [SET_BITS-1:0] op_set,
   input  logic                op_done,
   output logic                rst_stall,
   output logic                flush_stall,
   output logic                busy,
   output logic                done_valid,
   input  logic                done_ready,
   output logic                done_is_flush
`ifdef LLC_SEQ_CYCLE_CNT_EN
   ,
   output logic [31:0]         cycle_cnt
`endif
);

   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

   llc_seq_state_t      state_q, state_d;
   logic [SET_BITS-1:0] set_q, set_d;
   logic                kind_q, kind_d;
   logic                walking;

   // Reset lands in ISSUE so power-on performs a reset walk without a command.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SEQ_ISSUE;
         set_q   <= '0;
         kind_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         kind_q  <= kind_d;
      end
   end

   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      kind_d  = kind_q;
      unique case (state_q)
         SEQ_IDLE: begin
            if (cmd_valid) begin
               kind_d  = cmd_is_flush;
               set_d   = '0;
               state_d = SEQ_ISSUE;
            end
         end
         SEQ_ISSUE: begin
            if (op_ready) state_d = SEQ_WAIT;
         end
         SEQ_WAIT: begin
            // Terminal compare comes first so the set index never wraps.
            if (op_done) begin
               if (set_q == LAST_SET) begin
                  state_d = SEQ_RESP;
               end else begin
                  set_d   = set_q + 1'b1;
                  state_d = SEQ_ISSUE;
               end
            end
         end
         SEQ_RESP: begin
            if (done_ready) state_d = SEQ_IDLE;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   assign walking       = (state_q == SEQ_ISSUE) || (state_q == SEQ_WAIT);
   assign cmd_ready     = (state_q == SEQ_IDLE);
   assign op_valid      = (state_q == SEQ_ISSUE);
   assign op_is_flush   = kind_q;
   assign op_set        = set_q;
   assign rst_stall     = walking && !kind_q;
   assign flush_stall   = walking && kind_q;
   assign busy          = (state_q != SEQ_IDLE);
   assign done_valid    = (state_q == SEQ_RESP);
   assign done_is_flush = kind_q;

`ifdef LLC_SEQ_CYCLE_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // The walk's final cycle (into RESP) is not counted, so a stall-free walk ends at 2*SETS-1.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == SEQ_IDLE && state_d == SEQ_ISSUE) begin
         cnt_d = '0;
      end else if (walking && state_d != SEQ_RESP && cnt_q != '1) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Directed self-checking bench for llc_rst_flush_seq (optionally with LLC_SEQ_CYCLE_CNT_EN).
module tb_llc_rst_flush_seq;

   localparam int SETS     = 1024;
   localparam int SET_BITS = 10;

   logic                clk = 1'b0;
   logic                rst;
   logic                cmd_valid, cmd_ready, cmd_is_flush;
   logic                op_valid, op_ready, op_is_flush, op_done;
   logic [SET_BITS-1:0] op_set;
   logic                rst_stall, flush_stall, busy;
   logic                done_valid, done_ready, done_is_flush;
`ifdef LLC_SEQ_CYCLE_CNT_EN
   logic [31:0]         cycle_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic auto_done = 1'b0;
   logic man_done  = 1'b0;
   logic hs_prev   = 1'b0;
   assign op_done = auto_done | man_done;

   // Monitor-owned counters (cumulative); the main process snapshots them per walk.
   int op_cnt   = 0;
   int seq_bad  = 0;
   int last_set = -1;
   // Main-owned per-walk expectations.
   int   walk_base = 0;
   int   base_bad  = 0;
   logic exp_kind  = 1'b0;

   llc_rst_flush_seq #(.SETS(SETS), .SET_BITS(SET_BITS)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_flush(cmd_is_flush),
      .op_valid(op_valid), .op_ready(op_ready), .op_is_flush(op_is_flush),
      .op_set(op_set), .op_done(op_done),
      .rst_stall(rst_stall), .flush_stall(flush_stall), .busy(busy),
      .done_valid(done_valid), .done_ready(done_ready), .done_is_flush(done_is_flush)
`ifdef LLC_SEQ_CYCLE_CNT_EN
      , .cycle_cnt(cycle_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Pipeline model: op_done pulses for one cycle right after each accepted op.
   always @(negedge clk) begin
      if (!rst) begin
         hs_prev   = 1'b0;
         auto_done = 1'b0;
      end else begin
         auto_done = hs_prev;
         hs_prev   = op_valid && op_ready;
         if (op_valid && op_ready) begin
            if (int'(op_set) != (op_cnt - walk_base) || op_is_flush != exp_kind) seq_bad++;
            last_set = int'(op_set);
            op_cnt++;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_walk(input logic kind);
      exp_kind  = kind;
      walk_base = op_cnt;
      base_bad  = seq_bad;
   endtask

   // Runs until done_valid, counting cycles where the wrong stall pattern is shown.
   task automatic run_walk(input logic kind, output int ok, output int stall_bad);
      ok = 0;
      stall_bad = 0;
      for (int i = 0; i < 2 * SETS + 50; i++) begin
         if (done_valid) begin
            ok = 1;
            break;
         end
         if (kind ? (!flush_stall || rst_stall) : (!rst_stall || flush_stall)) stall_bad++;
         tick();
      end
   endtask

   initial begin
      int ok, bad, found;
      rst = 1'b0;
      cmd_valid = 1'b0; cmd_is_flush = 1'b0;
      op_ready = 1'b1; done_ready = 1'b0;

      // Reset values
      repeat (3) tick();
      check_eq("rst_op_valid", op_valid, 1);
      check_eq("rst_op_set", op_set, 0);
      check_eq("rst_rst_stall", rst_stall, 1);
      check_eq("rst_flush_stall", flush_stall, 0);
      check_eq("rst_done_valid", done_valid, 0);
      check_eq("rst_cmd_ready", cmd_ready, 0);
      check_eq("rst_busy", busy, 1);

      // Power-on reset walk, zero stall
      start_walk(1'b0);
      rst = 1'b1;
      run_walk(1'b0, ok, bad);
      check_eq("pon_timeout", ok, 1);
      check_eq("pon_stall_pattern", bad, 0);
      check_eq("pon_op_count", op_cnt - walk_base, SETS);
      check_eq("pon_seq", seq_bad - base_bad, 0);
      check_eq("pon_last_set", last_set, SETS - 1);
      check_eq("pon_done_is_flush", done_is_flush, 0);
      check_eq("pon_rst_stall_clr", rst_stall, 0);
      check_eq("pon_op_valid_resp", op_valid, 0);
`ifdef LLC_SEQ_CYCLE_CNT_EN
      check_eq("pon_cycle_cnt", cycle_cnt, 2 * SETS - 1);
`endif

      // Response held off by done_ready
      repeat (3) tick();
      check_eq("hold_done_valid", done_valid, 1);
      check_eq("hold_cmd_ready", cmd_ready, 0);
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      check_eq("idle_done_valid", done_valid, 0);
      check_eq("idle_cmd_ready", cmd_ready, 1);
      check_eq("idle_busy", busy, 0);
`ifdef LLC_SEQ_CYCLE_CNT_EN
      check_eq("idle_cycle_cnt_hold", cycle_cnt, 2 * SETS - 1);
`endif

      // Spurious op_done in IDLE
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      check_eq("idle_spurious_busy", busy, 0);
      check_eq("idle_spurious_ready", cmd_ready, 1);

      // Flush command, then 5-cycle op_ready stall with a spurious op_done inside it
      op_ready = 1'b0;
      cmd_valid = 1'b1; cmd_is_flush = 1'b1;
      start_walk(1'b1);
      tick();
      cmd_valid = 1'b0; cmd_is_flush = 1'b0;
      check_eq("fl_cmd_ready", cmd_ready, 0);
      check_eq("fl_flush_stall", flush_stall, 1);
      check_eq("fl_rst_stall", rst_stall, 0);
      check_eq("fl_op_valid", op_valid, 1);
      check_eq("fl_op_set", op_set, 0);
      check_eq("fl_op_is_flush", op_is_flush, 1);
`ifdef LLC_SEQ_CYCLE_CNT_EN
      check_eq("fl_cycle_cnt_clr", cycle_cnt, 0);
`endif
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         man_done = (i == 2);
         tick();
         man_done = 1'b0;
         if (!op_valid || op_set != 0) bad++;
      end
      check_eq("fl_stall_hold", bad, 0);
`ifdef LLC_SEQ_CYCLE_CNT_EN
      check_eq("fl_cycle_cnt_stall", cycle_cnt, 5);
`endif
      op_ready = 1'b1;
      run_walk(1'b1, ok, bad);
      check_eq("fl_timeout", ok, 1);
      check_eq("fl_stall_pattern", bad, 0);
      check_eq("fl_op_count", op_cnt - walk_base, SETS);
      check_eq("fl_seq", seq_bad - base_bad, 0);
      check_eq("fl_last_set", last_set, SETS - 1);
      check_eq("fl_done_is_flush", done_is_flush, 1);
      check_eq("fl_flush_stall_clr", flush_stall, 0);
`ifdef LLC_SEQ_CYCLE_CNT_EN
      check_eq("fl_cycle_cnt", cycle_cnt, 2 * SETS + 4);
`endif
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      check_eq("fl_idle_busy", busy, 0);

      // Flush aborted by async reset while waiting on set 500
      cmd_valid = 1'b1; cmd_is_flush = 1'b1;
      start_walk(1'b1);
      tick();
      cmd_valid = 1'b0; cmd_is_flush = 1'b0;
      found = 0;
      for (int i = 0; i < 1200; i++) begin
         if (op_set == 500 && !op_valid && busy && !done_valid) begin
            found = 1;
            break;
         end
         tick();
      end
      check_eq("abort_reach_500", found, 1);
      #1 rst = 1'b0;
      #1;
      check_eq("abort_op_set", op_set, 0);
      check_eq("abort_op_valid", op_valid, 1);
      check_eq("abort_rst_stall", rst_stall, 1);
      check_eq("abort_flush_stall", flush_stall, 0);
      check_eq("abort_done_valid", done_valid, 0);
      check_eq("abort_cmd_ready", cmd_ready, 0);
      repeat (2) tick();

      // Release reset; late op_done in ISSUE must be ignored
      op_ready = 1'b0;
      man_done = 1'b1;
      start_walk(1'b0);
      rst = 1'b1;
      tick();
      man_done = 1'b0;
      check_eq("post_rst_op_set", op_set, 0);
      check_eq("post_rst_op_valid", op_valid, 1);
      op_ready = 1'b1;
      run_walk(1'b0, ok, bad);
      check_eq("rw_timeout", ok, 1);
      check_eq("rw_stall_pattern", bad, 0);
      check_eq("rw_op_count", op_cnt - walk_base, SETS);
      check_eq("rw_seq", seq_bad - base_bad, 0);
      check_eq("rw_last_set", last_set, SETS - 1);
      check_eq("rw_done_is_flush", done_is_flush, 0);
`ifdef LLC_SEQ_CYCLE_CNT_EN
      check_eq("rw_cycle_cnt", cycle_cnt, 2 * SETS);
`endif
      done_ready = 1'b1;
      tick();
      done_ready = 1'b0;
      check_eq("rw_idle_cmd_ready", cmd_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
